// File: rtl/ccx_pkg.sv
// Shared types and constants for the core complex memory arbiter.
// Requester IDs double as the select value on the shared bus port.
package ccx_pkg;

  localparam logic CCX_REQ_IMEM = 1'b0;
  localparam logic CCX_REQ_DMEM = 1'b1;

  localparam int CCX_AW = 39;
  localparam int CCX_DW = 64;

  typedef enum logic {
    LK_OPEN = 1'b0,
    LK_HELD = 1'b1
  } ccx_lock_e;

endpackage

// File: rtl/ccx_rr_pick2.sv
// Two-way requester picker: round-robin on a tie when rr=1,
// otherwise dmem wins the tie.
import ccx_pkg::*;

module ccx_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr,
  output logic       sel
);

  always_comb begin
    sel = last;
    unique case (req)
      2'b01:   sel = CCX_REQ_IMEM;
      2'b10:   sel = CCX_REQ_DMEM;
      2'b11:   sel = rr ? ~last : CCX_REQ_DMEM;
      default: sel = last;
    endcase
  end

endmodule

// File: rtl/ccx_mem_arbiter.sv
// Shares one downstream memory bus port between imem and dmem,
// locking a stalled request and routing each response to its owner.
import ccx_pkg::*;

module ccx_mem_arbiter #(
  parameter int AW = CCX_AW,
  parameter int DW = CCX_DW,
  parameter bit RR = 1'b1
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            i_req,
  output logic            i_gnt,
  input  logic [AW-1:0]   i_addr,
  input  logic            i_wen,
  input  logic [DW/8-1:0] i_strb,
  input  logic [DW-1:0]   i_wdata,
  output logic [DW-1:0]   i_rdata,
  output logic            i_err,
  input  logic            d_req,
  output logic            d_gnt,
  input  logic [AW-1:0]   d_addr,
  input  logic            d_wen,
  input  logic [DW/8-1:0] d_strb,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_err,
  output logic            m_req,
  input  logic            m_gnt,
  output logic [AW-1:0]   m_addr,
  output logic            m_wen,
  output logic [DW/8-1:0] m_strb,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_err
);

  ccx_lock_e lock_q, lock_d;
  logic      lock_own_q, lock_own_d;
  logic      last_gnt_q, last_gnt_d;
  logic      rsp_vld_q, rsp_vld_d;
  logic      rsp_own_q, rsp_own_d;

  logic pick_sel;
  logic sel;
  logic sel_req;
  logic hs;
  logic rsp_on;

  ccx_rr_pick2 u_pick (
    .req  ({d_req, i_req}),
    .last (last_gnt_q),
    .rr   (RR),
    .sel  (pick_sel)
  );

  // A stalled request keeps the bus until it completes or is withdrawn.
  assign sel     = (lock_q == LK_HELD) ? lock_own_q : pick_sel;
  assign sel_req = (sel == CCX_REQ_DMEM) ? d_req : i_req;
  assign m_req   = sel_req & ~g_reset;
  assign hs      = m_req & m_gnt;

  assign i_gnt = hs & (sel == CCX_REQ_IMEM);
  assign d_gnt = hs & (sel == CCX_REQ_DMEM);

  always_comb begin
    m_addr  = i_addr;
    m_wen   = i_wen;
    m_strb  = i_strb;
    m_wdata = i_wdata;
    if (sel == CCX_REQ_DMEM) begin
      m_addr  = d_addr;
      m_wen   = d_wen;
      m_strb  = d_strb;
      m_wdata = d_wdata;
    end
  end

  assign rsp_on = rsp_vld_q & ~g_reset;

  always_comb begin
    i_rdata = '0;
    i_err   = 1'b0;
    d_rdata = '0;
    d_err   = 1'b0;
    if (rsp_on) begin
      if (rsp_own_q == CCX_REQ_DMEM) begin
        d_rdata = m_rdata;
        d_err   = m_err;
      end else begin
        i_rdata = m_rdata;
        i_err   = m_err;
      end
    end
  end

  always_comb begin
    lock_d     = lock_q;
    lock_own_d = lock_own_q;
    last_gnt_d = last_gnt_q;
    rsp_vld_d  = hs;
    rsp_own_d  = rsp_own_q;
    unique case (lock_q)
      LK_OPEN: begin
        if (m_req && !m_gnt) begin
          lock_d     = LK_HELD;
          lock_own_d = sel;
        end
      end
      LK_HELD: begin
        if (m_gnt || !sel_req) begin
          lock_d = LK_OPEN;
        end
      end
      default: lock_d = LK_OPEN;
    endcase
    if (hs) begin
      last_gnt_d = sel;
      rsp_own_d  = sel;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      lock_q     <= LK_OPEN;
      lock_own_q <= CCX_REQ_IMEM;
      last_gnt_q <= CCX_REQ_DMEM;
      rsp_vld_q  <= 1'b0;
      rsp_own_q  <= CCX_REQ_IMEM;
    end else begin
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
      last_gnt_q <= last_gnt_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_own_q  <= rsp_own_d;
    end
  end

endmodule
